udp_tx_arbiter: RTL
===================

Name: udp_tx_arbiter

Overview:
- Shares the single UDP transmit path (etx FIFO plus tx_enable/length sideband into the udp core) between two packet sources: port 0 (command replies) and port 1 (CameraLink line data).
- Arbitrates round-robin and streams one packet's 64-bit words from the granted source FIFO into the etx FIFO.
- Drives tx_data_length/tx_total_length, kicks transmission, then waits for the etx FIFO to drain before granting again.
- Sits between comctromodule's sources and udp, in the clk_50MHz domain.

Parameters:
- MAX_LEN, 1472: largest legal UDP payload in bytes.
- MIN_WAIT, 4: cycles after kick before etx_empty is sampled.
- TIMEOUT, 200000: WAIT_TX watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock (clk_50MHz)
- nrst  in  1  asynchronous active-low reset
- req0, req1  in  1  packet pending on port n; held until done_n
- len0, len1  in  16  payload byte count for port n; stable while req_n is high
- src_dout0, src_dout1  in  64  source FIFO read data; valid 1 cycle after src_rd_en_n
- src_empty0, src_empty1  in  1  source FIFO empty
- src_rd_en0, src_rd_en1  out  1  source FIFO read strobe
- done0, done1  out  1  1-cycle pulse: packet finished or rejected
- err_len  out  1  1-cycle pulse alongside done_n when len is rejected
- etx_din  out  64  etx FIFO write data
- etx_wr_en  out  1  etx FIFO write strobe
- etx_full  in  1  etx programmable-full; asserts with at least 2 free entries
- etx_empty  in  1  etx FIFO empty
- etx_fifo_rst  out  1  etx FIFO reset strobe
- tx_enable  out  1  1-cycle kick to the udp core
- tx_data_length  out  16  UDP length = len+8
- tx_total_length  out  16  IP total length = len+28
- grant  out  2  one-hot current owner; 00 when idle

Behaviour:
- Reset (asynchronous, nrst=0): state=IDLE, last-grant=port1 (so port0 wins first), all outputs 0. Source FIFOs are untouched.
- A reset mid-packet abandons the packet: no done pulse, and the partial etx contents are left in place for the next etx_fifo_rst.
- States:
  - IDLE: if any req_n, pick by round-robin (the port not granted last wins a tie) and go to CHECK. Exactly one grant bit is set.
  - CHECK: if len==0 or len>MAX_LEN, pulse done_n and err_len and return to IDLE. Otherwise:
    - latch words=(len+7)>>3 into a 9-bit counter;
    - latch tx_data_length=len+8 and tx_total_length=len+28 (16-bit, no overflow possible at MAX_LEN);
    - go to WAIT_EMPTY.
  - WAIT_EMPTY: stay until etx_empty=1, then go to XFER.
  - XFER:
    - src_rd_en_n = !src_empty_n && !etx_full && issued<words.
    - Each read produces etx_wr_en=1 with etx_din=src_dout_n on the following cycle (1-cycle registered pipeline).
    - When written==words, go to KICK.
    - A source that runs empty mid-packet stalls XFER indefinitely; no timeout applies here.
  - KICK: tx_enable=1 for exactly 1 cycle, then go to WAIT_TX.
  - WAIT_TX: count MIN_WAIT cycles, then wait for etx_empty=1; pulse done_n, clear grant, go to IDLE.
- Lengths hold their value from CHECK until the next CHECK.
- etx_full asserting mid-burst stops new reads at once; the single in-flight word is still written (covered by the 2-entry slack).
- If both ports request while busy, the port not served last wins next.
- Throughput: 1 word per cycle when unthrottled.
- Minimum packet overhead outside XFER: IDLE+CHECK+WAIT_EMPTY+KICK+MIN_WAIT cycles.

Optional Feature:
- Macro: UDP_TX_ARB_TIMEOUT_EN.
- With the macro defined:
  - a 20-bit counter runs in WAIT_TX;
  - reaching TIMEOUT pulses etx_fifo_rst for 1 cycle, pulses done_n and err_len, then returns to IDLE.
- Without the macro: etx_fifo_rst is tied to 0 and WAIT_TX waits forever.

Decomposition:
- Shared package/header holds:
  - state encodings IDLE..WAIT_TX (3 bits);
  - UDP_HDR_LEN=8 and IP_HDR_LEN=20;
  - the default MAX_LEN.
- One natural sub-module, rr_arb2: 2-way round-robin with a last-grant register and a one-hot grant output. All sequencing stays in the top-level block.

Test Plan:
- req0, len0=64, source holds 8 words, etx always empty/not full:
  - 8 consecutive etx_wr_en carrying the data in order;
  - tx_data_length=72, tx_total_length=92;
  - one tx_enable pulse, then done0 after etx_empty.
- req0 and req1 raised in the same cycle, both len=16 → port0 served first, then port1, then port0 again if both re-request.
- len1=13 → words=2 (ceil rounding), tx_data_length=21, tx_total_length=41.
- len0=0, then len0=1473 → done0 and err_len each pulse in the CHECK cycle; no etx_wr_en and no tx_enable.
- etx_full toggled every 3 cycles during a 100-word packet → exactly 100 writes, no loss or duplication, data order preserved.
- nrst pulsed low mid-XFER → all outputs 0 asynchronously and grant=00. With UDP_TX_ARB_TIMEOUT_EN and etx_empty held 0, etx_fifo_rst pulses TIMEOUT cycles after the kick.

Source files
------------

// File: rtl/udp_tx_arbiter_pkg.sv
// Shared definitions for the UDP transmit arbiter: sequencer state
// encoding, protocol header sizes and the default payload limit.
package udp_tx_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CHECK      = 3'd1,
        WAIT_EMPTY = 3'd2,
        XFER       = 3'd3,
        KICK       = 3'd4,
        WAIT_TX    = 3'd5
    } state_t;

    localparam int UDP_HDR_LEN = 8;
    localparam int IP_HDR_LEN  = 20;
    localparam int DEF_MAX_LEN = 1472;

endpackage

// File: rtl/udp_tx_arbiter_rr_arb2.sv
// Two-way round-robin picker with a last-grant register.
// Ports: clk, nrst, req0/req1 requests, take (commit the pick),
//        pick one-hot choice (00 when nothing is requested).
module rr_arb2 (
    input  logic       clk,
    input  logic       nrst,
    input  logic       req0,
    input  logic       req1,
    input  logic       take,
    output logic [1:0] pick
);

    // 1 = port 1 was granted last, so port 0 wins the first tie.
    logic last;

    always_comb begin
        pick = 2'b00;
        if (req0 && req1) begin
            pick = last ? 2'b01 : 2'b10;
        end else if (req0) begin
            pick = 2'b01;
        end else if (req1) begin
            pick = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            last <= 1'b1;
        end else if (take) begin
            last <= pick[1];
        end
    end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Shares the UDP transmit path between two packet sources: picks a port
// round-robin, copies its 64-bit words into the etx FIFO, sets the UDP/IP
// lengths, kicks the udp core and waits for the etx FIFO to drain.
// Ports: req/len/src_* per source, done/err_len status pulses, etx_* FIFO
//        write side, tx_enable/tx_*_length sideband, grant one-hot owner.
// Optional: define UDP_TX_ARB_TIMEOUT_EN to add a WAIT_TX watchdog that
//           resets the etx FIFO and reports an error after TIMEOUT cycles.
module udp_tx_arbiter
    import udp_tx_arbiter_pkg::*;
#(
    parameter int MAX_LEN  = DEF_MAX_LEN,
    parameter int MIN_WAIT = 4,
    parameter int TIMEOUT  = 200000
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] len0,
    input  logic [15:0] len1,
    input  logic [63:0] src_dout0,
    input  logic [63:0] src_dout1,
    input  logic        src_empty0,
    input  logic        src_empty1,
    output logic        src_rd_en0,
    output logic        src_rd_en1,
    output logic        done0,
    output logic        done1,
    output logic        err_len,
    output logic [63:0] etx_din,
    output logic        etx_wr_en,
    input  logic        etx_full,
    input  logic        etx_empty,
    output logic        etx_fifo_rst,
    output logic        tx_enable,
    output logic [15:0] tx_data_length,
    output logic [15:0] tx_total_length,
    output logic [1:0]  grant
);

    localparam logic [15:0] MAX_L = 16'(MAX_LEN);
    localparam logic [7:0]  MIN_W = 8'(MIN_WAIT);

    state_t      state, state_nx;
    logic [1:0]  grant_q, pick;
    logic        take;
    logic [15:0] sel_len;
    logic [63:0] sel_dout;
    logic        sel_empty;
    logic        len_bad, reject;
    logic [8:0]  words_calc, words_q, issued_q, written_q;
    logic        rd, wr_q;
    logic [7:0]  wait_q;
    logic        tx_done, timeout;

    rr_arb2 u_arb (
        .clk  (clk),
        .nrst (nrst),
        .req0 (req0),
        .req1 (req1),
        .take (take),
        .pick (pick)
    );

    assign sel_len   = grant_q[1] ? len1 : len0;
    assign sel_dout  = grant_q[1] ? src_dout1 : src_dout0;
    assign sel_empty = grant_q[1] ? src_empty1 : src_empty0;

    assign len_bad    = (sel_len == 16'd0) || (sel_len > MAX_L);
    assign reject     = (state == CHECK) && len_bad;
    // Only legal lengths are latched, so the 16-bit wrap never matters.
    assign words_calc = 9'((sel_len + 16'd7) >> 3);

    // Reads stop the same cycle etx_full rises; the one word already in
    // flight lands in the FIFO's guaranteed slack.
    assign rd = (state == XFER) && !sel_empty && !etx_full
                && (issued_q < words_q);

    assign tx_done = (state == WAIT_TX) && (wait_q == MIN_W) && etx_empty;

`ifdef UDP_TX_ARB_TIMEOUT_EN
    localparam logic [19:0] TMO_LAST = 20'(TIMEOUT - 1);
    logic [19:0] tmo_q;

    assign timeout      = (state == WAIT_TX) && !tx_done && (tmo_q == TMO_LAST);
    assign etx_fifo_rst = timeout;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tmo_q <= '0;
        end else if (state == KICK) begin
            tmo_q <= '0;
        end else if (state == WAIT_TX) begin
            tmo_q <= tmo_q + 20'd1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT == 0);
    assign timeout        = 1'b0;
    assign etx_fifo_rst   = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        take     = 1'b0;
        unique case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_nx = CHECK;
                    take     = 1'b1;
                end
            end
            CHECK:      state_nx = len_bad ? IDLE : WAIT_EMPTY;
            WAIT_EMPTY: if (etx_empty) state_nx = XFER;
            XFER:       if (written_q == words_q) state_nx = KICK;
            KICK:       state_nx = WAIT_TX;
            WAIT_TX:    if (tx_done || timeout) state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase
    end

    assign src_rd_en0 = rd && grant_q[0];
    assign src_rd_en1 = rd && grant_q[1];
    assign done0      = (reject || tx_done || timeout) && grant_q[0];
    assign done1      = (reject || tx_done || timeout) && grant_q[1];
    assign err_len    = reject || timeout;
    assign tx_enable  = (state == KICK);
    assign etx_wr_en  = wr_q;
    assign etx_din    = wr_q ? sel_dout : 64'd0;
    assign grant      = grant_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state           <= IDLE;
            grant_q         <= 2'b00;
            words_q         <= '0;
            issued_q        <= '0;
            written_q       <= '0;
            wr_q            <= 1'b0;
            wait_q          <= '0;
            tx_data_length  <= '0;
            tx_total_length <= '0;
        end else begin
            state <= state_nx;
            wr_q  <= rd;
            if (take) begin
                grant_q <= pick;
            end else if (state_nx == IDLE) begin
                grant_q <= 2'b00;
            end
            if (state == CHECK) begin
                issued_q  <= '0;
                written_q <= '0;
                if (!len_bad) begin
                    words_q         <= words_calc;
                    tx_data_length  <= sel_len + 16'(UDP_HDR_LEN);
                    tx_total_length <= sel_len + 16'(UDP_HDR_LEN + IP_HDR_LEN);
                end
            end else begin
                issued_q  <= issued_q + {8'd0, rd};
                written_q <= written_q + {8'd0, wr_q};
            end
            if (state == KICK) begin
                wait_q <= '0;
            end else if ((state == WAIT_TX) && (wait_q != MIN_W)) begin
                wait_q <= wait_q + 8'd1;
            end
        end
    end

endmodule
